// File: rtl/my_reduce_pipe_if.sv
// Handshake bundle for my_reduce_pipe: producer side (in_*) and consumer side (out_*).
// The master modport is the environment that drives words and takes results; the slave modport is the reducer.
interface my_reduce_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic             out_bit;
   logic [1:0]       out_op;

   modport master (
      output in_valid, in_data, in_op, out_ready,
      input  in_ready, out_valid, out_bit, out_op
   );

   modport slave (
      input  in_valid, in_data, in_op, out_ready,
      output in_ready, out_valid, out_bit, out_op
   );
endinterface

// File: rtl/my_reduce_pipe.sv
// Pipelined bitwise reducer (OR/AND/XOR/NOR). It uses a balanced two-input tree with one register level per tree level.
// A valid/ready handshake runs through the stages, and a stage accepts whenever it is empty or its successor accepts.
module my_reduce_pipe #(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   my_reduce_pipe_if.slave   bus
);
   localparam int LEVELS = $clog2(WIDTH);

   if ((WIDTH < 2) || (WIDTH > 256) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
      $error("my_reduce_pipe: WIDTH must be a power of two in 2..256");
   end

   function automatic logic reduce2(input logic a, input logic b, input logic [1:0] op);
      logic r;
      case (op)
         2'b01:   r = a & b;
         2'b10:   r = a ^ b;
         default: r = a | b;
      endcase
      return r;
   endfunction

   // Every tree level is packed into one vector. Level 0 is the input word, and level k sits at offset 2W - (2W >> k).
   logic [2*WIDTH-2:0] tree_s;
   logic [LEVELS:0]    vld_s;
   logic [1:0]         op_s [0:LEVELS];
   logic [LEVELS+1:1]  ready_s;

   assign tree_s[WIDTH-1:0] = bus.in_data;
   assign vld_s[0]          = bus.in_valid;
   assign op_s[0]           = bus.in_op;

   // Backward ready chain: a stage accepts when it is empty or its successor accepts.
   always_comb begin
      ready_s[LEVELS+1] = bus.out_ready;
      for (int k = LEVELS; k >= 1; k--) begin
         ready_s[k] = !vld_s[k] || ready_s[k+1];
      end
   end

   for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
      localparam int NW   = WIDTH >> k;
      localparam int SOFF = 2*WIDTH - ((2*WIDTH) >> (k-1));
      localparam int DOFF = 2*WIDTH - ((2*WIDTH) >> k);

      logic [NW-1:0] p_r;
      logic [NW-1:0] p_nxt_s;
      logic          valid_r;
      logic [1:0]    op_r;

      // Combine adjacent pairs of the previous level under that level's op.
      always_comb begin
         p_nxt_s = '0;
         for (int i = 0; i < NW; i++) begin
            p_nxt_s[i] = reduce2(tree_s[SOFF + 2*i], tree_s[SOFF + 2*i + 1], op_s[k-1]);
         end
      end

      // Stage register. A bubble clears valid_r and leaves the stale data in place.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_r <= 1'b0;
            op_r    <= 2'b00;
            p_r     <= '0;
         end else if (ready_s[k]) begin
            valid_r <= vld_s[k-1];
            if (vld_s[k-1]) begin
               op_r <= op_s[k-1];
               p_r  <= p_nxt_s;
            end
         end
      end

      assign tree_s[DOFF +: NW] = p_r;
      assign vld_s[k]           = valid_r;
      assign op_s[k]            = op_r;
   end

   // NOR is an OR tree with a single inversion applied at the output.
   assign bus.in_ready  = ready_s[1];
   assign bus.out_valid = vld_s[LEVELS];
   assign bus.out_op    = op_s[LEVELS];
   assign bus.out_bit   = tree_s[2*WIDTH-2] ^ (op_s[LEVELS] == 2'b11);
endmodule

// File: tb/tb_my_reduce_pipe.sv
// Directed bench for my_reduce_pipe: WIDTH=16 checks for reset, latency, backpressure, bubbles and random flow.
// A width sweep runs on 2/4/64/256-bit instances. All expected values come from constants or a linear-fold reference.
module tb_my_reduce_pipe;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   my_reduce_pipe_if #(.WIDTH(16))  b16 ();
   my_reduce_pipe_if #(.WIDTH(2))   b2 ();
   my_reduce_pipe_if #(.WIDTH(4))   b4 ();
   my_reduce_pipe_if #(.WIDTH(64))  b64 ();
   my_reduce_pipe_if #(.WIDTH(256)) b256 ();

   my_reduce_pipe #(.WIDTH(16))  u16  (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
   my_reduce_pipe #(.WIDTH(2))   u2   (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
   my_reduce_pipe #(.WIDTH(4))   u4   (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
   my_reduce_pipe #(.WIDTH(64))  u64  (.clk(clk), .rst_n(rst_n), .bus(b64.slave));
   my_reduce_pipe #(.WIDTH(256)) u256 (.clk(clk), .rst_n(rst_n), .bus(b256.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ref_red(input logic [255:0] d, input int w, input logic [1:0] op);
      logic r;
      r = d[0];
      for (int i = 1; i < w; i++) begin
         case (op)
            2'b01:   r = r & d[i];
            2'b10:   r = r ^ d[i];
            default: r = r | d[i];
         endcase
      end
      if (op == 2'b11) r = ~r;
      return r;
   endfunction

   task automatic sweep_drive(input logic v, input logic [255:0] d, input logic [1:0] op);
      b2.in_valid   = v; b2.in_data   = d[1:0];  b2.in_op   = op;
      b4.in_valid   = v; b4.in_data   = d[3:0];  b4.in_op   = op;
      b64.in_valid  = v; b64.in_data  = d[63:0]; b64.in_op  = op;
      b256.in_valid = v; b256.in_data = d;       b256.in_op = op;
   endtask

   task automatic sw_check(input string tag, input logic v, input logic b, input logic [1:0] o,
                           input int lat, input int k, input int w, input logic [255:0] d, input logic [1:0] op);
      chk({tag, "_valid"}, 32'(v), 32'(k == lat - 1));
      if (v) begin
         chk({tag, "_bit"}, 32'(b), 32'(ref_red(d, w, op)));
         chk({tag, "_op"}, 32'(o), 32'(op));
      end
   endtask

   // Scoreboarded stream on the 16-bit instance. It runs either as directed with a stall window, or with random valid/ready.
   task automatic stream(input int n, input int stall_len, input bit rnd);
      logic [2:0]  exp_q [$];
      logic [15:0] dir_d [0:7] = '{16'h0000, 16'hFFFF, 16'h8001, 16'h00F0,
                                   16'hAAAA, 16'h1234, 16'hFFFF, 16'h0000};
      int sent = 0, got = 0, cnt = 0, cyc = 0, first_seen = -1;
      bit was_stalled = 1'b0;
      logic prev_bit = 1'b0;
      logic [1:0] prev_op = 2'b00;
      logic [2:0] e;
      while (got < n && cyc < 20*n + 100) begin
         b16.in_valid = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
         b16.in_data  = rnd ? 16'($urandom) : dir_d[sent % 8];
         b16.in_op    = rnd ? 2'($urandom_range(0, 3)) : 2'(sent % 4);
         if (rnd) b16.out_ready = ($urandom_range(0, 2) != 0);
         else     b16.out_ready = !(first_seen >= 0 && cyc > first_seen && cyc <= first_seen + stall_len);
         #1;
         chk("in_ready", 32'(b16.in_ready), 32'((cnt < 4) || b16.out_ready));
         if (cnt == 0) chk("idle_valid", 32'(b16.out_valid), 32'd0);
         if (was_stalled) begin
            chk("hold_valid", 32'(b16.out_valid), 32'd1);
            chk("hold_bit", 32'(b16.out_bit), 32'(prev_bit));
            chk("hold_op", 32'(b16.out_op), 32'(prev_op));
         end
         if (b16.out_valid && first_seen < 0) first_seen = cyc;
         if (b16.out_valid && b16.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("out_bit", 32'(b16.out_bit), 32'(e[0]));
               chk("out_op", 32'(b16.out_op), 32'(e[2:1]));
               got++;
               cnt--;
            end
         end
         if (b16.in_valid && b16.in_ready) begin
            exp_q.push_back({b16.in_op, ref_red(256'(b16.in_data), 16, b16.in_op)});
            sent++;
            cnt++;
         end
         was_stalled = b16.out_valid && !b16.out_ready;
         prev_bit    = b16.out_bit;
         prev_op     = b16.out_op;
         tick();
         cyc++;
      end
      chk("drained", 32'(got), 32'(n));
      b16.in_valid  = 1'b0;
      b16.out_ready = 1'b1;
      repeat (6) tick();
      chk("no_dup", 32'(b16.out_valid), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] lat_d [0:3] = '{16'h0001, 16'hFFFE, 16'h0007, 16'h0000};
      logic        lat_b [0:3] = '{1'b1, 1'b0, 1'b1, 1'b1};
      int          pos   [0:4] = '{0, 1, 3, 63, 255};
      logic [255:0] wv;

      rst_n = 1'b0;
      b16.in_valid = 1'b0; b16.in_data = 16'h0000; b16.in_op = 2'b00; b16.out_ready = 1'b1;
      sweep_drive(1'b0, '0, 2'b00);
      b2.out_ready = 1'b1; b4.out_ready = 1'b1; b64.out_ready = 1'b1; b256.out_ready = 1'b1;
      repeat (2) tick();
      chk("rst_valid", 32'(b16.out_valid), 32'd0);
      chk("rst_bit", 32'(b16.out_bit), 32'd0);
      chk("rst_op", 32'(b16.out_op), 32'd0);
      chk("rst_in_ready", 32'(b16.in_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Four back-to-back ops. The first is visible after the 4th acceptance edge, the rest on consecutive cycles.
      for (int i = 0; i < 4; i++) begin
         b16.in_valid = 1'b1; b16.in_data = lat_d[i]; b16.in_op = 2'(i);
         #1;
         chk("lat_in_ready", 32'(b16.in_ready), 32'd1);
         tick();
         if (i < 3) chk("lat_early_valid", 32'(b16.out_valid), 32'd0);
      end
      b16.in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         chk("lat_valid", 32'(b16.out_valid), 32'd1);
         chk("lat_bit", 32'(b16.out_bit), 32'(lat_b[j]));
         chk("lat_op", 32'(b16.out_op), 32'(j));
         tick();
      end
      chk("lat_after", 32'(b16.out_valid), 32'd0);

      // Bubble collapse: OR of 0x0100 (=1), two idles, then AND of 0x7FFF (=0), while out_ready is low.
      b16.out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         b16.in_valid = (c == 0) || (c == 3);
         b16.in_data  = (c == 0) ? 16'h0100 : 16'h7FFF;
         b16.in_op    = (c == 0) ? 2'b00 : 2'b01;
         #1;
         chk("bub_in_ready", 32'(b16.in_ready), 32'd1);
         tick();
      end
      b16.in_valid = 1'b0;
      chk("bub_v1", 32'(b16.out_valid), 32'd1);
      chk("bub_b1", 32'(b16.out_bit), 32'd1);
      chk("bub_o1", 32'(b16.out_op), 32'd0);
      b16.out_ready = 1'b1;
      tick();
      chk("bub_v2", 32'(b16.out_valid), 32'd1);
      chk("bub_b2", 32'(b16.out_bit), 32'd0);
      chk("bub_o2", 32'(b16.out_op), 32'd1);
      tick();
      chk("bub_v3", 32'(b16.out_valid), 32'd0);

      stream(8, 6, 1'b0);

      // Reset with four NOR-of-zero words in flight. Any leaked result would show out_bit=1.
      for (int i = 0; i < 4; i++) begin
         b16.in_valid = 1'b1; b16.in_data = 16'h0000; b16.in_op = 2'b11;
         tick();
      end
      b16.in_valid = 1'b0;
      chk("mid_valid_pre", 32'(b16.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(b16.out_valid), 32'd0);
      chk("mid_rst_bit", 32'(b16.out_bit), 32'd0);
      chk("mid_rst_op", 32'(b16.out_op), 32'd0);
      chk("mid_rst_in_ready", 32'(b16.in_ready), 32'd1);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("post_rst_valid", 32'(b16.out_valid), 32'd0);
         chk("post_rst_bit", 32'(b16.out_bit), 32'd0);
         chk("post_rst_in_ready", 32'(b16.in_ready), 32'd1);
      end

      // Width sweep: walking-one and all-ones words under each op, sent one at a time.
      for (int t = 0; t < 6; t++) begin
         for (int o = 0; o < 4; o++) begin
            wv = '0;
            if (t < 5) wv[pos[t]] = 1'b1;
            else       wv = '1;
            sweep_drive(1'b1, wv, 2'(o));
            #1;
            chk("sw_in_ready", 32'(b2.in_ready & b4.in_ready & b64.in_ready & b256.in_ready), 32'd1);
            tick();
            sweep_drive(1'b0, wv, 2'(o));
            for (int k = 0; k <= 8; k++) begin
               sw_check("w2",   b2.out_valid,   b2.out_bit,   b2.out_op,   1, k, 2,   wv, 2'(o));
               sw_check("w4",   b4.out_valid,   b4.out_bit,   b4.out_op,   2, k, 4,   wv, 2'(o));
               sw_check("w64",  b64.out_valid,  b64.out_bit,  b64.out_op,  6, k, 64,  wv, 2'(o));
               sw_check("w256", b256.out_valid, b256.out_bit, b256.out_op, 8, k, 256, wv, 2'(o));
               tick();
            end
         end
      end

      stream(1000, 0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
